// File: rtl/lsu_pkg.sv
// Shared definitions for the RV64 load/store unit:
// funct3 encodings, FSM state type and access-legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RD,
        RMW_RD,
        ST_WR,
        RESP
    } lsu_state_t;

    // size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double
    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [2:0] lane
    );
        logic ok;
        unique case (size)
            2'd0: ok = 1'b1;
            2'd1: ok = (lane[0] == 1'b0);
            2'd2: ok = (lane[1:0] == 2'b00);
            2'd3: ok = (lane == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic is_illegal(
        input logic       is_store,
        input logic [2:0] funct3
    );
        return is_store ? funct3[2] : (funct3 == 3'd7);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: little-endian load extraction with
// sign/zero extension, and byte-merge of store data into a dword.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      lane,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] read_data,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merge_data
);

    logic [5:0]      shift;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] size_mask;
    logic [XLEN-1:0] lane_mask;

    assign shift   = {lane, 3'b000};
    assign shifted = read_data >> shift;

    always_comb begin
        load_data = '0;
        unique case (size)
            2'd0: load_data = is_unsigned
                ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'd1: load_data = is_unsigned
                ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            2'd2: load_data = is_unsigned
                ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            2'd3: load_data = shifted;
        endcase
    end

    always_comb begin
        size_mask = '0;
        unique case (size)
            2'd0: size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            2'd1: size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            2'd2: size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            2'd3: size_mask = '1;
        endcase
    end

    // Only the addressed lanes take the store bytes; the rest keep memory.
    assign lane_mask  = size_mask << shift;
    assign merge_data = (read_data & ~lane_mask)
                      | ((store_data << shift) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: turns byte-addressed B/H/W/D accesses into
// doubleword memory reads, writes and read-modify-writes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int XLEN       = 64
) (
    input  logic                  clockInput,
    input  logic                  resetInput,
    input  logic                  reqValidInput,
    output logic                  reqReadyOutput,
    input  logic                  reqIsStoreInput,
    input  logic [2:0]            reqFunct3Input,
    input  logic [ADDR_WIDTH-1:0] reqAddressInput,
    input  logic [XLEN-1:0]       reqStoreDataInput,
    output logic                  respValidOutput,
    output logic [XLEN-1:0]       respLoadDataOutput,
    output logic                  respErrorOutput,
    output logic                  memReadOutput,
    output logic                  memWriteOutput,
    output logic [ADDR_WIDTH-1:0] memAddressOutput,
    output logic [XLEN-1:0]       memWriteDataOutput,
    input  logic [XLEN-1:0]       memReadDataInput
);

    lsu_state_t            state;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]       store_data;
    logic [XLEN-1:0]       merge;
    logic [XLEN-1:0]       resp_data;
    logic                  resp_error;

    logic                  req_bad;
    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       merge_data;
    logic                  drive_addr;

    assign req_bad = is_illegal(reqIsStoreInput, reqFunct3Input)
                  || !is_aligned(reqFunct3Input[1:0], reqAddressInput[2:0]);

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .lane       (addr[2:0]),
        .size       (funct3[1:0]),
        .is_unsigned(funct3[2]),
        .read_data  (memReadDataInput),
        .store_data (store_data),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            state      <= IDLE;
            is_store   <= 1'b0;
            funct3     <= '0;
            addr       <= '0;
            store_data <= '0;
            merge      <= '0;
            resp_data  <= '0;
            resp_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValidInput) begin
                        is_store   <= reqIsStoreInput;
                        funct3     <= reqFunct3Input;
                        addr       <= reqAddressInput;
                        store_data <= reqStoreDataInput;
                        resp_data  <= '0;
                        resp_error <= req_bad;
                        if (req_bad)
                            state <= RESP;
                        else if (!reqIsStoreInput)
                            state <= LOAD_RD;
                        else if (reqFunct3Input == F3_D)
                            state <= ST_WR;
                        else
                            state <= RMW_RD;
                    end
                end
                LOAD_RD: begin
                    resp_data <= load_data;
                    state     <= RESP;
                end
                RMW_RD: begin
                    merge <= merge_data;
                    state <= ST_WR;
                end
                ST_WR: begin
                    state <= RESP;
                end
                RESP: begin
                    resp_data  <= '0;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reqReadyOutput     = (state == IDLE);
    assign respValidOutput    = (state == RESP);
    assign respLoadDataOutput = resp_data;
    assign respErrorOutput    = resp_error;

    assign drive_addr = (state == LOAD_RD)
                     || (state == RMW_RD)
                     || (state == ST_WR);

    // Write is gated by reset so an aborted store never commits.
    always_comb begin
        memReadOutput      = (state == LOAD_RD) || (state == RMW_RD);
        memWriteOutput     = (state == ST_WR) && !resetInput;
        memAddressOutput   = '0;
        memWriteDataOutput = '0;
        if (drive_addr)
            memAddressOutput = {3'b000, addr[ADDR_WIDTH-1:3]};
        if (state == ST_WR)
            memWriteDataOutput = (is_store && funct3 == F3_D)
                               ? store_data : merge;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model,
// directed test-plan cases, reset aborts and random traffic.
module tb_load_store_unit;

    localparam int AW = 48;
    localparam int XL = 64;

    logic          clockInput = 1'b0;
    logic          resetInput = 1'b1;
    logic          reqValidInput = 1'b0;
    logic          reqReadyOutput;
    logic          reqIsStoreInput = 1'b0;
    logic [2:0]    reqFunct3Input = '0;
    logic [AW-1:0] reqAddressInput = '0;
    logic [XL-1:0] reqStoreDataInput = '0;
    logic          respValidOutput;
    logic [XL-1:0] respLoadDataOutput;
    logic          respErrorOutput;
    logic          memReadOutput;
    logic          memWriteOutput;
    logic [AW-1:0] memAddressOutput;
    logic [XL-1:0] memWriteDataOutput;
    logic [XL-1:0] memReadDataInput;

    load_store_unit #(.ADDR_WIDTH(AW), .XLEN(XL)) dut (
        .clockInput        (clockInput),
        .resetInput        (resetInput),
        .reqValidInput     (reqValidInput),
        .reqReadyOutput    (reqReadyOutput),
        .reqIsStoreInput   (reqIsStoreInput),
        .reqFunct3Input    (reqFunct3Input),
        .reqAddressInput   (reqAddressInput),
        .reqStoreDataInput (reqStoreDataInput),
        .respValidOutput   (respValidOutput),
        .respLoadDataOutput(respLoadDataOutput),
        .respErrorOutput   (respErrorOutput),
        .memReadOutput     (memReadOutput),
        .memWriteOutput    (memWriteOutput),
        .memAddressOutput  (memAddressOutput),
        .memWriteDataOutput(memWriteDataOutput),
        .memReadDataInput  (memReadDataInput)
    );

    always #5 clockInput = ~clockInput;

    // 64-dword data memory: asynchronous read, write on the edge
    logic [63:0] mem [64];
    assign memReadDataInput = mem[memAddressOutput[5:0]];
    always @(posedge clockInput)
        if (memWriteOutput)
            mem[memAddressOutput[5:0]] <= memWriteDataOutput;

    // Reference model: a flat little-endian byte array
    byte unsigned rb [512];

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t        sbq [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    logic [47:0] exp_addr = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [2:0] f3,
                                             input logic [8:0] a);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = rb[int'(a) + i];
        if (!f3[2] && n < 8 && v[8*n-1])
            v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
        return v;
    endfunction

    // Cycle bookkeeping: accept edge, strobe counts, strobe address
    always @(posedge clockInput) begin
        cyc++;
        if (!resetInput && reqValidInput && reqReadyOutput) begin
            acc_cyc = cyc;
            rd_cnt  = 0;
            wr_cnt  = 0;
        end else begin
            if (memReadOutput) rd_cnt++;
            if (memWriteOutput) wr_cnt++;
            if (memReadOutput || memWriteOutput)
                check("mem_addr", memAddressOutput, exp_addr);
        end
    end

    // Monitor: pops the scoreboard on each response pulse
    always @(negedge clockInput) begin
        exp_t e;
        if (respValidOutput) begin
            resp_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got valid=1 want none");
            end else begin
                e = sbq.pop_front();
                check("resp_data", respLoadDataOutput, e.data);
                check("resp_err", respErrorOutput, e.err);
                check("latency", cyc - acc_cyc, e.lat);
                check("rd_strobes", rd_cnt, e.rd);
                check("wr_strobes", wr_cnt, e.wr);
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [47:0] a, input logic [63:0] d);
        @(negedge clockInput);
        check("ready", reqReadyOutput, 1);
        reqValidInput     = 1'b1;
        reqIsStoreInput   = st;
        reqFunct3Input    = f3;
        reqAddressInput   = a;
        reqStoreDataInput = d;
        exp_addr          = a >> 3;
        @(posedge clockInput);
        #1 reqValidInput = 1'b0;
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3,
                          input logic [47:0] a, input logic [63:0] d);
        exp_t e;
        int n;
        int target;
        logic [8:0] ba;
        n  = 1 << f3[1:0];
        ba = a[8:0];
        e.err  = st ? (f3 >= 3'd4) : (f3 == 3'd7);
        if ((int'(a[2:0]) % n) != 0) e.err = 1'b1;
        e.data = '0;
        e.rd   = 0;
        e.wr   = 0;
        e.lat  = 0;
        if (!e.err) begin
            if (!st) begin
                e.data = ref_load(f3, ba);
                e.rd   = 1;
                e.lat  = 1;
            end else begin
                for (int i = 0; i < n; i++)
                    rb[int'(ba) + i] = d[8*i +: 8];
                e.wr  = 1;
                e.rd  = (n == 8) ? 0 : 1;
                e.lat = 1 + e.rd;
            end
        end
        sbq.push_back(e);
        target = resp_cnt + 1;
        issue(st, f3, a, d);
        for (int i = 0; i < 12 && resp_cnt < target; i++)
            @(posedge clockInput);
        if (resp_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no response want one (addr %h)", a);
            sbq.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, reqReadyOutput, 1);
        check({tag, "_valid"}, respValidOutput, 0);
        check({tag, "_err"}, respErrorOutput, 0);
        check({tag, "_data"}, respLoadDataOutput, 0);
        check({tag, "_mrd"}, memReadOutput, 0);
        check({tag, "_mwr"}, memWriteOutput, 0);
        check({tag, "_maddr"}, memAddressOutput, 0);
        check({tag, "_mwdata"}, memWriteDataOutput, 0);
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] w;
        logic [47:0] a;
        logic [2:0]  f3;
        logic        st;

        p = 64'h8877_6655_4433_2211;
        for (int i = 0; i < 512; i++) rb[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) rb[16 + i] = p[8*i +: 8];
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = rb[8*k + i];
            mem[k] = w;
        end

        repeat (3) @(posedge clockInput);
        @(negedge clockInput);
        check_reset_state("reset");
        resetInput = 1'b0;

        do_req(0, 3'd0, 48'h17, '0);
        do_req(0, 3'd4, 48'h17, '0);
        do_req(0, 3'd1, 48'h16, '0);
        do_req(0, 3'd6, 48'h14, '0);
        do_req(0, 3'd3, 48'h10, '0);
        do_req(1, 3'd0, 48'h11, 64'hAB);
        do_req(0, 3'd3, 48'h10, '0);
        do_req(1, 3'd3, 48'h10, 64'h0123_4567_89AB_CDEF);
        do_req(0, 3'd3, 48'h10, '0);
        do_req(0, 3'd2, 48'h13, '0);
        do_req(1, 3'd1, 48'h15, 64'hFFFF);
        do_req(0, 3'd7, 48'h10, '0);
        do_req(1, 3'd4, 48'h10, 64'h55);
        do_req(0, 3'd3, 48'h8000_0000_0010, '0);

        // Reset during the read half of an SB
        issue(1, 3'd0, 48'h11, 64'hCD);
        @(negedge clockInput);
        check("abort_rmw_rd", memReadOutput, 1);
        resetInput = 1'b1;
        @(posedge clockInput);
        @(negedge clockInput);
        check_reset_state("abort_rd");
        resetInput = 1'b0;

        // Reset during the write half of an SB
        issue(1, 3'd0, 48'h12, 64'hEE);
        @(negedge clockInput);
        @(negedge clockInput);
        check("abort_st_wr", memWriteOutput, 1);
        resetInput = 1'b1;
        @(posedge clockInput);
        @(negedge clockInput);
        check_reset_state("abort_wr");
        resetInput = 1'b0;
        do_req(0, 3'd3, 48'h10, '0);

        for (int t = 0; t < 250; t++) begin
            st = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = 48'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0)
                a = a & ~48'((1 << f3[1:0]) - 1);
            do_req(st, f3, a, {$urandom, $urandom});
        end

        repeat (3) @(negedge clockInput);
        for (int k = 0; k < 64; k++) begin
            for (int i = 0; i < 8; i++) w[8*i +: 8] = rb[8*k + i];
            check($sformatf("mem_%0d", k), mem[k], w);
        end
        check("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the 64-bit data memory, which is doubleword-indexed with an asynchronous read and a write on the clock edge.
- Converts byte-addressed RV64 loads and stores (B/H/W/D, signed and unsigned) into doubleword memory accesses.
- Performs lane extraction with sign or zero extension for loads, and read-modify-write for sub-doubleword stores.
- Flags misaligned accesses and illegal funct3 values without touching memory.

Parameters:
- ADDR_WIDTH, 48, width of byte addresses from the core and of the memory address port.
- XLEN, 64, width of the data path and of each memory word.

Ports:
- clockInput  in  1  single clock; all state updates on the rising edge.
- resetInput  in  1  synchronous, active-high reset.
- reqValidInput  in  1  request valid.
- reqReadyOutput  out  1  unit can accept a request (high only in IDLE).
- reqIsStoreInput  in  1  1 = store, 0 = load.
- reqFunct3Input  in  3  RISC-V funct3: LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6; SB=0, SH=1, SW=2, SD=3.
- reqAddressInput  in  ADDR_WIDTH  byte address.
- reqStoreDataInput  in  XLEN  store data; the value is taken from the low bits.
- respValidOutput  out  1  one-cycle completion pulse.
- respLoadDataOutput  out  XLEN  extended load result; 0 for stores and for errors.
- respErrorOutput  out  1  misaligned access or illegal funct3; valid while respValidOutput is high.
- memReadOutput  out  1  memory read strobe.
- memWriteOutput  out  1  memory write enable.
- memAddressOutput  out  ADDR_WIDTH  doubleword index = {3'b0, addr[ADDR_WIDTH-1:3]}.
- memWriteDataOutput  out  XLEN  full doubleword to write.
- memReadDataInput  in  XLEN  doubleword read from memory (combinational).

Behaviour:
- Reset values: state=IDLE, reqReadyOutput=1, respValidOutput=0, respErrorOutput=0, respLoadDataOutput=0, memReadOutput=0, memWriteOutput=0, memAddressOutput=0, memWriteDataOutput=0. All request latches are cleared.
- Byte order is little-endian. Lane = addr[2:0].
- Alignment rules: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- Illegal funct3: load funct3=7, or store funct3>=4.
- Accept: on a rising edge with reqValidInput & reqReadyOutput, latch isStore, funct3, addr and storeData. No request is accepted outside IDLE.
- States:
  - IDLE: on accept, go to RESP if error; LOAD_RD if load; ST_WR if SD; RMW_RD otherwise.
  - LOAD_RD: memReadOutput=1, address driven. At the edge, extract and extend the lane into the response register, then go to RESP.
  - RMW_RD: memReadOutput=1. At the edge, merge the store bytes into memReadDataInput and place the result in the merge register, then go to ST_WR.
  - ST_WR: memWriteOutput=1; memWriteDataOutput = merge register, or storeData for SD. Memory commits at the edge, then go to RESP.
  - RESP: respValidOutput=1 for exactly one cycle, then go to IDLE. There is no response back-pressure.
- Latency, counted from the accept edge E0:
  - Error: respValidOutput is high in the cycle after E0.
  - Load and SD: respValidOutput is high in the cycle after E1.
  - SB/SH/SW: respValidOutput is high in the cycle after E2.
  - Back-to-back throughput is one request per (latency+1) cycles.
- memWriteOutput is gated with !resetInput, so reset asserted during ST_WR commits no write. Reset in any state returns to IDLE at that edge with all outputs at their reset values.
- Memory outputs are 0 in every state that does not drive them.
- Address bits above the memory depth pass through unchanged; the memory truncates them.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - the state enum (IDLE, LOAD_RD, RMW_RD, ST_WR, RESP);
  - a function for the alignment check.
- One combinational sub-module, lsu_lane_align, performs load extraction with sign/zero extension and store byte-merge given the lane and size.

Test Plan:
- Preload dword index 2 = 0x8877665544332211. LB at 0x17 -> respLoadDataOutput=0xFFFFFFFFFFFFFF88, error=0, respValidOutput 2 cycles after the accept edge.
- Same preload. LBU at 0x17 -> 0x0000000000000088. LH at 0x16 -> 0xFFFFFFFFFFFF8877. LWU at 0x14 -> 0x0000000088776655. LD at 0x10 -> 0x8877665544332211.
- SB data=0xAB at 0x11 -> one read strobe, then one write of 0x887766554433AB11 to index 2, respValid 3 cycles after accept. SD 0x0123456789ABCDEF at 0x10 -> a single write with no read cycle.
- LW at 0x13 and SH at 0x15 -> respErrorOutput=1 in the cycle after accept; memReadOutput and memWriteOutput stay 0; memory unchanged.
- Load funct3=7 and store funct3=4 -> error=1 and respLoadDataOutput=0.
- Assert resetInput during RMW_RD, and separately during ST_WR, of an SB -> no memory write, IDLE next cycle, reqReadyOutput=1, no respValidOutput pulse.
